// File: rtl/univ_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register slice.
//   mode_t     : 3-bit operation select
//   MODE_*     : operation encodings applied on an enabled rising edge
// Optional build macro used elsewhere in the slice: UNIV_SHIFT_REG_PARITY_EN
// ---------------------------------------------------------------------------
package usr_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROL  = 3'b100;
    localparam mode_t MODE_ROR  = 3'b101;
    localparam mode_t MODE_CLR  = 3'b110;
    localparam mode_t MODE_RSVD = 3'b111;

endpackage : usr_pkg

// File: rtl/univ_shift_reg_if.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_if
// Bundles the control/data signals of univ_shift_reg.
//   enable, mode, D, sin_l, sin_r : driven by the master (stimulus side)
//   Q, sout, shift_cnt, done      : driven by the slave (the register)
//   parity                        : present only with UNIV_SHIFT_REG_PARITY_EN
// Modports: master (drives controls), slave (the register itself).
// ---------------------------------------------------------------------------
interface univ_shift_reg_if
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             enable;
    mode_t            mode;
    logic [WIDTH-1:0] D;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] Q;
    logic             sout;
    logic [CW-1:0]    shift_cnt;
    logic             done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic             parity;
`endif

    modport master (
        output enable, mode, D, sin_l, sin_r,
        input  Q, sout, shift_cnt, done
`ifdef UNIV_SHIFT_REG_PARITY_EN
        , input parity
`endif
    );

    modport slave (
        input  enable, mode, D, sin_l, sin_r,
        output Q, sout, shift_cnt, done
`ifdef UNIV_SHIFT_REG_PARITY_EN
        , output parity
`endif
    );

endinterface : univ_shift_reg_if

// File: rtl/univ_shift_reg_shift_counter.sv
// ---------------------------------------------------------------------------
// shift_counter
// CW-bit counter of shift/rotate edges, saturating at WIDTH, plus a
// registered one-cycle done pulse on the WIDTH-1 -> WIDTH transition.
//   clock, reset : rising-edge clock, async active-low reset
//   enable       : clock enable; when low the count holds and done drops
//   inc          : a shift/rotate happens on this edge
//   clr          : LOAD/CLEAR on this edge; wins over inc and re-arms done
//   shift_cnt    : current count
//   done         : pulse, high for the cycle after the count hits WIDTH
// ---------------------------------------------------------------------------
module shift_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] shift_cnt,
    output logic          done
);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (enable) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc && (cnt_q != CNT_MAX)) begin
                cnt_d  = cnt_q + 1'b1;
                // Only the step into saturation fires; saturated shifts skip this branch.
                done_d = (cnt_q == CNT_MAX - 1'b1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign shift_cnt = cnt_q;
    assign done      = done_q;

endmodule : shift_counter

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
// WIDTH-bit universal register: hold, load, shift left/right, rotate
// left/right, clear, with clock enable, shift counter and done pulse.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears all state
//   bus   : univ_shift_reg_if.slave
//           enable, mode, D, sin_l, sin_r in; Q, sout, shift_cnt, done out
// Build macro UNIV_SHIFT_REG_PARITY_EN adds registered bus.parity = ^Q.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    univ_shift_reg_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             cnt_inc;
    logic             cnt_clr;

    always_comb begin
        q_d     = q_q;
        sout_d  = sout_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (bus.enable) begin
            case (bus.mode)
                MODE_LOAD: begin
                    q_d     = bus.D;
                    cnt_clr = 1'b1;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], bus.sin_l};
                    sout_d  = q_q[WIDTH-1];
                    cnt_inc = 1'b1;
                end
                MODE_SHR: begin
                    q_d     = {bus.sin_r, q_q[WIDTH-1:1]};
                    sout_d  = q_q[0];
                    cnt_inc = 1'b1;
                end
                MODE_ROL: begin
                    q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d  = q_q[WIDTH-1];
                    cnt_inc = 1'b1;
                end
                MODE_ROR: begin
                    q_d     = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d  = q_q[0];
                    cnt_inc = 1'b1;
                end
                MODE_CLR: begin
                    q_d     = '0;
                    sout_d  = 1'b0;
                    cnt_clr = 1'b1;
                end
                default: ; // HOLD and the reserved code leave everything as is
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            sout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
        end
    end

    shift_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_shift_counter (
        .clock     (clock),
        .reset     (reset),
        .enable    (bus.enable),
        .inc       (cnt_inc),
        .clr       (cnt_clr),
        .shift_cnt (bus.shift_cnt),
        .done      (bus.done)
    );

    assign bus.Q    = q_q;
    assign bus.sout = sout_q;

`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic parity_q, parity_d;

    // Parity of the value being written this edge, so it lines up with Q.
    always_comb begin
        parity_d = parity_q;
        if (bus.enable) begin
            parity_d = ^q_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.parity = parity_q;
`endif

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
// Directed bench for univ_shift_reg (WIDTH=8). The driver applies one
// operation per cycle and pushes the hand-computed post-edge response
// {Q, sout, shift_cnt, done} into exp_q; the monitor pops and compares
// one entry per clock, 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int EW    = WIDTH + 1 + CW + 1;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    univ_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks;
    int errors;
    int step_no;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [EW-1:0] e;
        int idx;
        idx = 0;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                idx++;
                check($sformatf("step%0d_q", idx),    64'(bus.Q),         64'(e[EW-1 -: WIDTH]));
                check($sformatf("step%0d_sout", idx), 64'(bus.sout),      64'(e[CW+1]));
                check($sformatf("step%0d_cnt", idx),  64'(bus.shift_cnt), 64'(e[CW:1]));
                check($sformatf("step%0d_done", idx), 64'(bus.done),      64'(e[0]));
`ifdef UNIV_SHIFT_REG_PARITY_EN
                check($sformatf("step%0d_parity", idx), 64'(bus.parity), 64'(^e[EW-1 -: WIDTH]));
`endif
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic en, input mode_t m, input logic [WIDTH-1:0] d,
                        input logic sl, input logic sr,
                        input logic [WIDTH-1:0] eq, input logic es,
                        input logic [CW-1:0] ec, input logic ed);
        @(negedge clock);
        bus.enable = en;
        bus.mode   = m;
        bus.D      = d;
        bus.sin_l  = sl;
        bus.sin_r  = sr;
        exp_q.push_back({eq, es, ec, ed});
        step_no++;
        @(posedge clock);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_q"},    64'(bus.Q),         64'h0);
        check({tag, "_sout"}, 64'(bus.sout),      64'h0);
        check({tag, "_cnt"},  64'(bus.shift_cnt), 64'h0);
        check({tag, "_done"}, 64'(bus.done),      64'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        logic [WIDTH-1:0] shl_q[8];
        logic             shl_s[8];
        checks  = 0;
        errors  = 0;
        step_no = 0;
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.mode   = MODE_HOLD;
        bus.D      = '0;
        bus.sin_l  = 1'b0;
        bus.sin_r  = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_state("in_reset");
        reset = 1'b1;

        // Load, then shift left with sin_l=1 until saturation.
        step(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0, 1'b0);
        shl_q = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
        shl_s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0, shl_q[i], shl_s[i], CW'(i + 1), (i == 7));
        end
        // Saturated: no re-pulse.
        step(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 4'd8, 1'b0);

        // Rotate; sout is unchanged by LOAD.
        step(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 4'd0, 1'b0);
        step(1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0, 8'hC0, 1'b1, 4'd1, 1'b0);
        step(1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h81, 1'b1, 4'd2, 1'b0);
        step(1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 4'd3, 1'b0);

        // Enable gating.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 4'd3, 1'b0);
        end

        // Bring count to 7 with SHR, then collide with LOAD.
        step(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 4'd4, 1'b0);
        step(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'd5, 1'b0);
        step(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd6, 1'b0);
        step(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd7, 1'b0);
        step(1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 4'd0, 1'b0);
        step(1'b1, MODE_RSVD, 8'hFF, 1'b1, 1'b1, 8'h3C, 1'b0, 4'd0, 1'b0);

        // Three SHR with sin_r=1, then reset between edges.
        step(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1, 8'h9E, 1'b0, 4'd1, 1'b0);
        step(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1, 8'hCF, 1'b0, 4'd2, 1'b0);
        step(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1, 8'hE7, 1'b1, 4'd3, 1'b0);
        @(negedge clock);
        bus.enable = 1'b0;
        #1;
        check("pre_reset_cnt", 64'(bus.shift_cnt), 64'd3);
        reset = 1'b0;
        #1;
        check_reset_state("async_reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_state("reset_held");
        reset = 1'b1;

        // Parity pair, then rotate and clear.
        step(1'b1, MODE_LOAD, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 4'd0, 1'b0);
        step(1'b1, MODE_LOAD, 8'h03, 1'b0, 1'b0, 8'h03, 1'b0, 4'd0, 1'b0);
        step(1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0, 8'h81, 1'b1, 4'd1, 1'b0);
        step(1'b1, MODE_CLR,  8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0);
        step(1'b1, MODE_HOLD, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_univ_shift_reg
